// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one I2C master controller between NUM_REQ requesters,
// counting byte strobes per transaction and enforcing a bus-free gap between grants.
module i2c_txn_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int LEN_W     = 4,
   parameter int TIMEOUT   = 4096,
   parameter int STOP_WAIT = 64
) (
   input  logic                     core_clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*8-1:0]     req_addr,
   input  logic [NUM_REQ*LEN_W-1:0] req_len,
   input  logic                     i2c_tx_byte_done,
   input  logic                     i2c_rx_byte_done,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       done,
   output logic [NUM_REQ-1:0]       err,
   output logic                     busy,
   output logic                     i2c_enable,
   output logic [7:0]               i2c_slave_address,
   output logic [1:0]               state
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam int GAP_W = $clog2(STOP_WAIT + 1);

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STOP_WAIT - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   logic [IDX_W-1:0]   last_grant;
   logic [IDX_W-1:0]   winner;
   logic [NUM_REQ-1:0] winner_oh;
   logic [LEN_W-1:0]   remaining;
   logic [TMR_W-1:0]   timer;
   logic [GAP_W-1:0]   gap_cnt;
   logic               counted;

   logic [7:0]       addr_arr [NUM_REQ];
   logic [LEN_W-1:0] len_arr  [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g] = req_addr[8*g +: 8];
      assign len_arr[g]  = req_len[LEN_W*g +: LEN_W];
   end

   // Circular search starting just above the previous winner.
   always_comb begin
      int  cand;
      logic found;
      cand   = 0;
      found  = 1'b0;
      winner = last_grant;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = int'(last_grant) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!found && req_valid[cand[IDX_W-1:0]]) begin
            found  = 1'b1;
            winner = cand[IDX_W-1:0];
         end
      end
   end

   assign winner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;

   // Latched rw bit picks which controller strobe counts; the other is ignored.
   assign counted    = i2c_slave_address[0] ? i2c_rx_byte_done : i2c_tx_byte_done;
   assign busy       = (state != ST_IDLE);
   assign i2c_enable = (state == ST_RUN);

   always_ff @(posedge core_clk) begin
      if (rst) begin
         state             <= ST_IDLE;
         last_grant        <= IDX_W'(NUM_REQ - 1);
         grant             <= '0;
         req_ready         <= '0;
         done              <= '0;
         err               <= '0;
         i2c_slave_address <= '0;
         remaining         <= '0;
         timer             <= '0;
         gap_cnt           <= '0;
      end else begin
         req_ready <= '0;
         done      <= '0;
         err       <= '0;
         case (state)
            ST_IDLE: begin
               if (|req_valid) begin
                  state             <= ST_RUN;
                  grant             <= winner_oh;
                  req_ready         <= winner_oh;
                  last_grant        <= winner;
                  i2c_slave_address <= addr_arr[winner];
                  remaining         <= len_arr[winner];
                  timer             <= '0;
               end
            end
            ST_RUN: begin
               // A strobe on the expiry cycle wins over the timeout.
               if (counted) begin
                  timer <= '0;
                  if (remaining == '0) begin
                     state   <= ST_GAP;
                     done    <= grant;
                     grant   <= '0;
                     gap_cnt <= '0;
                  end else begin
                     remaining <= remaining - LEN_W'(1);
                  end
               end else if (timer == TMR_LAST) begin
                  state   <= ST_GAP;
                  err     <= grant;
                  grant   <= '0;
                  gap_cnt <= '0;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) state <= ST_IDLE;
               else gap_cnt <= gap_cnt + GAP_W'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/i2c_txn_arbiter.md
# i2c_txn_arbiter

Round-robin transaction arbiter and sequencer that shares the single I2C master controller between `NUM_REQ` requesters. It latches the winning requester's slave address and byte count, then drives the controller's `enable` and `slave_address`. It counts completed bytes from the controller's FIFO strobes and drops `enable` after the last byte. It also recovers from address NACK or a stalled bus with a timeout, and enforces a bus-free gap before the next grant.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8)
- `LEN_W`, 4: width of byte-count field; bytes per transaction = `req_len + 1`
- `TIMEOUT`, 4096: core_clk cycles allowed between byte strobes before abort
- `STOP_WAIT`, 64: core_clk cycles `enable` stays low after a transaction, before next grant
- `core_clk`  in  1  sole clock. Same clock as the controller's core_clk. Must run ≥4× i2c_clk.
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_REQ  per-requester transaction request, level
- `req_addr`  in  NUM_REQ*8  per-requester {7-bit address, rw}. Bit 0 = rw (1 = read). Requester i occupies bits [8i+7:8i].
- `req_len`  in  NUM_REQ*LEN_W  per-requester byte count minus one
- `i2c_tx_byte_done`  in  1  controller fifo_tx_enable strobe
- `i2c_rx_byte_done`  in  1  controller fifo_rx_enable strobe
- `req_ready`  out  NUM_REQ  one-cycle one-hot accept pulse
- `grant`  out  NUM_REQ  one-hot, held for the whole transaction. Selects the external data mux.
- `done`  out  NUM_REQ  one-cycle one-hot pulse on successful completion
- `err`  out  NUM_REQ  one-cycle one-hot pulse on timeout abort
- `busy`  out  1  high in any state except IDLE
- `i2c_enable`  out  1  to controller enable
- `i2c_slave_address`  out  8  to controller slave_address, latched copy of winner's req_addr

## Operation
- States:
  - IDLE: no grant, `i2c_enable` = 0.
  - RUN: grant held, `i2c_enable` = 1, byte counting and timeout active.
  - GAP: grant released, `enable` low, gap counter running.
- IDLE → RUN when `req_valid` is non-zero.
  - Winner is the first set bit searching upward, circularly, from `last_grant+1`.
  - Latch the winner's `req_addr` into `i2c_slave_address` and `req_len` into `remaining`.
  - Set `grant` to the winner, pulse `req_ready` for the winner, and set `last_grant` to the winner.
- Byte strobe in RUN:
  - Counted strobe = `i2c_rx_byte_done` if the latched rw is 1, else `i2c_tx_byte_done`. The other strobe is ignored.
  - On a counted strobe: if `remaining` = 0, go to GAP and pulse `done`. Otherwise decrement `remaining`.
- Timeout in RUN:
  - The timer resets on entering RUN and on every counted strobe.
  - When the timer reaches `TIMEOUT-1`, go to GAP and pulse `err`.
  - This covers address NACK, where the controller stops without any strobe.
- GAP:
  - Count `STOP_WAIT` cycles, then go to IDLE.
  - The next arbitration happens in the IDLE cycle.
- Changes to `req_valid`, `req_addr` or `req_len` while granted are ignored. Dropping `req_valid` does not abort the transaction.
- Counters are sized to hold their parameter value. `remaining` is `LEN_W` bits and never wraps below 0.

## Timing
- Reset values (the cycle after `rst` is sampled high): state IDLE, `last_grant` = NUM_REQ-1 (so requester 0 wins first), and all outputs 0, including `i2c_slave_address` = 0x00.
- Reset mid-transaction: `i2c_enable` drops on the next edge. No `done` or `err` is issued.
- Grant latency: `req_valid` sampled in IDLE at edge N → `grant`, `req_ready`, `i2c_enable` and `i2c_slave_address` are all valid from edge N+1.
- `i2c_enable` falls one cycle after the final counted strobe, the same cycle `done` pulses. The core_clk ≥4× i2c_clk constraint guarantees the controller sees `enable` = 0 in its ACK state.
- `grant` falls together with `i2c_enable`.
- Minimum gap from `done`/`err` to the next `req_ready` = `STOP_WAIT` + 1 cycles.
- A counted strobe in the same cycle as timer expiry: the strobe wins, the timer resets, and no `err` is issued.
- `i2c_tx_byte_done` and `i2c_rx_byte_done` high in the same cycle count as at most one byte.
- A strobe in IDLE or GAP is ignored.

## Test plan
- Single write: requester 2, `req_addr` = 0xA0, `req_len` = 2, three tx strobes 20 cycles apart.
  - Expect `req_ready[2]` pulse, grant = 0100, and `i2c_slave_address` = 0xA0.
  - Expect `done[2]` one cycle after the 3rd strobe, `enable` low for 64 cycles, then IDLE.
- Round-robin: all four `req_valid` held high, each transaction `req_len` = 0.
  - Expect grant order 0, 1, 2, 3, 0.
- Address NACK: `req_addr` = 0x51 (read), no strobes.
  - Expect `err` exactly `TIMEOUT` cycles after grant, then GAP.
  - Expect no `done`.
- Wrong-direction strobe: read transaction with `req_len` = 0; a tx strobe is ignored, then an rx strobe arrives.
  - Expect `done` only after the rx strobe.
- Expiry collision: counted strobe on the exact timeout cycle.
  - Expect no `err`, `remaining` decremented, timer restarted.
- Reset mid-RUN: assert `rst` with `remaining` = 3.
  - Expect all outputs 0 next cycle and the next grant going to requester 0.
